// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register controller: frame geometry,
// FSM state encoding and the read/write opcode values carried in frame bit 15.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;  // bits in a well-formed frame
    localparam int CMD_BITS   = 8;   // opcode + address phase
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchroniser with registered edge pulses.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   din      : asynchronous input pin
//   level    : synchronised level (stage 3, aligned with the pulses' source)
//   rise     : one-clk pulse after a 0->1 transition of din
//   fall     : one-clk pulse after a 1->0 transition of din
// The pulses are registered, so an edge on the pin shows up on rise/fall
// three clk edges later (two synchroniser stages + one detect stage).
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_reg, s2_reg, s3_reg;
    logic rise_reg, fall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            s3_reg   <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            s1_reg   <= din;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            rise_reg <= s2_reg & ~s3_reg;
            fall_reg <= ~s2_reg & s3_reg;
        end
    end

    assign level = s3_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave that sequences 16-bit host frames into a bank of 8-bit
// configuration registers, fully oversampled in the clk domain.
// Frame (MSB first): bit15 = 1 write / 0 read, bits14:8 address, bits7:0 data.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   sclk, cs_n : SPI clock / active-low select (asynchronous pins)
//   mosi, miso : SPI data in / out
//   regs_out   : flattened register bank, reg i at [8i+7:8i]
//   wr_strobe  : one-clk pulse when a write is committed
//   wr_addr    : address of the last committed write
//   frame_err  : sticky flag for frames whose length is not 16 bits
//   err_clr    : synchronous clear of frame_err (a new error wins)
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int           NREGS     = 4,
    parameter logic [7:0]   RESET_VAL = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic [NREGS*8-1:0]  regs_out,
    output logic                wr_strobe,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic                frame_err,
    input  logic                err_clr
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_lvl;
    logic sclk_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;

    sync_edge u_sync_sclk (.clk(clk), .rst(rst), .din(sclk),
                           .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
    // cs_n stages reset to 0: a rise seen straight after reset lands in IDLE
    // and is ignored, so a frame cut short by reset never raises an error.
    sync_edge u_sync_cs   (.clk(clk), .rst(rst), .din(cs_n),
                           .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall));
    // Only the level of mosi matters; its edge pulses are not needed.
    sync_edge u_sync_mosi (.clk(clk), .rst(rst), .din(mosi),
                           .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

    state_t              state_reg;
    logic [4:0]          cnt_reg;
    logic [DATA_W-1:0]   rx_reg;
    logic [DATA_W-1:0]   tx_reg;
    logic                op_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                miso_reg;
    logic                wr_strobe_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic                frame_err_reg;

    logic [ADDR_W-1:0]   cmd_addr_next;
    logic [DATA_W-1:0]   rd_byte;
    logic                addr_in_range;
    logic                frame_ok;
    logic                commit_en;

    // Address as it stands on the 8th rising edge: rx holds op + addr[6:1].
    assign cmd_addr_next = {rx_reg[5:0], mosi_lvl};

    // Read-back mux; out-of-range addresses fall through to 0x00.
    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (cmd_addr_next == i[ADDR_W-1:0])
                rd_byte = regs_out[i*8 +: 8];
        end
    end

    assign addr_in_range = ({25'd0, addr_reg} < NREGS);
    assign frame_ok      = (state_reg != ST_IDLE) && (cnt_reg == 5'(FRAME_BITS));
    assign commit_en     = cs_rise && frame_ok && (op_reg == OP_WR) && addr_in_range;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] q_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    q_reg <= RESET_VAL;
                else if (commit_en && (addr_reg == 7'(gi)))
                    q_reg <= rx_reg;
            end
            assign regs_out[gi*8 +: 8] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            op_reg        <= OP_RD;
            addr_reg      <= '0;
            miso_reg      <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            wr_strobe_reg <= 1'b0;
            if (err_clr)
                frame_err_reg <= 1'b0;

            // cs_n rise beats any sclk edge detected in the same clk.
            if (cs_rise) begin
                if (state_reg != ST_IDLE) begin
                    if (!frame_ok)
                        frame_err_reg <= 1'b1;
                    else if (commit_en) begin
                        wr_strobe_reg <= 1'b1;
                        wr_addr_reg   <= addr_reg;
                    end
                end
                state_reg <= ST_IDLE;
                miso_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            cnt_reg   <= '0;
                            rx_reg    <= '0;
                            tx_reg    <= '0;
                            state_reg <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            rx_reg  <= {rx_reg[6:0], mosi_lvl};
                            cnt_reg <= cnt_reg + 5'd1;
                            if (cnt_reg == 5'(CMD_BITS - 1)) begin
                                op_reg    <= rx_reg[6];
                                addr_reg  <= cmd_addr_next;
                                tx_reg    <= (rx_reg[6] == OP_RD) ? rd_byte : '0;
                                state_reg <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            rx_reg <= {rx_reg[6:0], mosi_lvl};
                            if (cnt_reg != 5'd31)
                                cnt_reg <= cnt_reg + 5'd1;
                        end else if (sclk_fall) begin
                            miso_reg <= tx_reg[7];
                            tx_reg   <= {tx_reg[6:0], 1'b0};
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign miso      = miso_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl (NREGS = 4, RESET_VAL = 0).
module tb_spi_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        err_clr = 1'b0;
    logic        miso;
    logic [31:0] regs_out;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    logic [15:0] cap;

    spi_reg_ctrl #(.NREGS(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .regs_out(regs_out), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .frame_err(frame_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_strobe) strobe_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drives cs_n low and shifts nbits of word MSB first (8 clk per half
    // period). miso is captured just before each sclk rise. cs_n is left low
    // unless coincide is set, in which case it rises with the last sclk rise.
    task automatic spi_frame(input int nbits, input logic [31:0] word,
                             input bit coincide, output logic [15:0] mcap);
        mcap = '0;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = word[i];
            repeat (8) @(negedge clk);
            mcap = {mcap[14:0], miso};
            sclk = 1'b1;
            if (coincide && i == 0) cs_n = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int s0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_regs", regs_out, 32'h0);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wraddr", {25'd0, wr_addr}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);

        // Write 0xA5 to reg 1 and check exact 4-clk latency.
        spi_frame(16, 32'h81A5, 1'b0, cap);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("wr1_early_regs", regs_out, 32'h0);
        check("wr1_early_stb", {31'd0, wr_strobe}, 32'd0);
        @(negedge clk);
        check("wr1_regs", regs_out, 32'h0000A500);
        check("wr1_strobe", {31'd0, wr_strobe}, 32'd1);
        check("wr1_addr", {25'd0, wr_addr}, 32'd1);
        @(negedge clk);
        check("wr1_stb_end", {31'd0, wr_strobe}, 32'd0);
        check("wr1_err", {31'd0, frame_err}, 32'd0);
        repeat (8) @(negedge clk);

        // Read back reg 1.
        s0 = strobe_cnt;
        spi_frame(16, 32'h0100, 1'b0, cap);
        end_frame();
        check("rd1_miso", {16'd0, cap}, 32'h00A5);
        check("rd1_regs", regs_out, 32'h0000A500);
        check("rd1_nostb", strobe_cnt - s0, 32'd0);
        check("idle_miso", {31'd0, miso}, 32'd0);

        // 15-bit frame: rejected.
        s0 = strobe_cnt;
        spi_frame(15, 32'h4155, 1'b0, cap);
        end_frame();
        check("f15_err", {31'd0, frame_err}, 32'd1);
        check("f15_regs", regs_out, 32'h0000A500);
        pulse_err_clr();
        check("f15_clr", {31'd0, frame_err}, 32'd0);

        // 17-bit frame: rejected; error survives a good write.
        spi_frame(17, 32'h104CD, 1'b0, cap);
        end_frame();
        check("f17_err", {31'd0, frame_err}, 32'd1);
        check("f17_regs", regs_out, 32'h0000A500);
        check("bad_nostb", strobe_cnt - s0, 32'd0);
        spi_frame(16, 32'h8377, 1'b0, cap);
        end_frame();
        check("wr3_regs", regs_out, 32'h7700A500);
        check("err_sticky", {31'd0, frame_err}, 32'd1);
        pulse_err_clr();
        check("err_clr", {31'd0, frame_err}, 32'd0);

        // Out-of-range write and read.
        s0 = strobe_cnt;
        spi_frame(16, 32'h90FF, 1'b0, cap);
        end_frame();
        check("oor_regs", regs_out, 32'h7700A500);
        check("oor_nostb", strobe_cnt - s0, 32'd0);
        check("oor_err", {31'd0, frame_err}, 32'd0);
        spi_frame(16, 32'h1000, 1'b0, cap);
        end_frame();
        check("oor_rd", {16'd0, cap}, 32'h0);

        // Reset mid-frame after 9 bits of a write to reg 2.
        s0 = strobe_cnt;
        spi_frame(9, 32'h104, 1'b0, cap);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_regs", regs_out, 32'h0);
        check("mrst_miso", {31'd0, miso}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        end_frame();
        check("mrst_err", {31'd0, frame_err}, 32'd0);
        check("mrst_nostb", strobe_cnt - s0, 32'd0);
        check("mrst_regs2", regs_out, 32'h0);
        spi_frame(16, 32'h823C, 1'b0, cap);
        end_frame();
        check("wr2_regs", regs_out, 32'h003C0000);
        check("wr2_addr", {25'd0, wr_addr}, 32'd2);

        // cs_n rises together with the 16th sclk rise: only 15 bits count.
        spi_frame(16, 32'h8155, 1'b1, cap);
        repeat (10) @(negedge clk);
        check("coin_err", {31'd0, frame_err}, 32'd1);
        check("coin_regs", regs_out, 32'h003C0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- SPI-slave controller that sequences host frames into a small bank of 8-bit configuration registers.
- Replaces direct SCLK/CS-clocked latching with an oversampled design in the system clock domain, so all outputs are synchronous to clk.
- Commits a write only when a frame has exactly the right length, and supports read-back on miso.
- Sits between the SPI pins and the LED/DAC/ADC control fabric; the top level instantiates it with clk tied to XTALCLK.

Parameters:
- NREGS, 4: number of 8-bit registers; legal range 1..128.
- RESET_VAL, 8'h00: value every register takes on reset.

Ports:
- clk  input  1  system clock (XTALCLK).
- rst  input  1  reset; asynchronous, active-high.
- sclk  input  1  SPI clock, asynchronous to clk; mode 0.
- cs_n  input  1  SPI chip select, active-low, asynchronous.
- mosi  input  1  SPI data in, MSB first.
- miso  output  1  SPI data out.
- regs_out  output  NREGS*8  flattened register bank; reg i occupies bits [8i+7:8i].
- wr_strobe  output  1  one-clk pulse when a register is committed.
- wr_addr  output  7  address of the last committed write.
- frame_err  output  1  sticky bad-frame flag.
- err_clr  input  1  synchronous clear of frame_err.

Behaviour:
Reset values (all asynchronous): regs = RESET_VAL, miso = 0, wr_strobe = 0, wr_addr = 0, frame_err = 0, state = IDLE, bit counter = 0, shift registers = 0.

Frame format, 16 bits, MSB first:
- bit15: 1 = write, 0 = read.
- bits14:8: address.
- bits7:0: data. Ignored for reads.

Synchronisation and timing:
- sclk, cs_n and mosi each pass through a 2-FF synchroniser; edges are detected from stage2 vs stage3.
- Host constraint: sclk frequency ≤ clk/8.
- Sample mosi on the detected sclk rising edge.
- Update miso on the detected sclk falling edge.

State machine:
- IDLE: wait for cs_n falling edge, then clear the bit counter and go to CMD.
- CMD: shift 8 bits. After the 8th rising edge, latch cmd/addr. For a read with addr < NREGS, load regs[addr] into the tx shifter; if addr ≥ NREGS, load 0x00. Go to DATA.
- DATA: shift 8 bits. miso presents tx MSB from the first falling edge after the CMD phase; it is 0 in all other states and phases.
- Bit counter: 5 bits, saturating at 31, so frames longer than 31 bits still count as bad.
- Any state, cs_n rising edge: evaluate the frame.
  - Count == 16, write, addr < NREGS: update regs[addr], pulse wr_strobe, set wr_addr.
  - Count == 16, write, addr ≥ NREGS: silently ignored; no strobe, no error.
  - Count == 16, read: no register change.
  - Count ≠ 16, including 0: discard the frame and set frame_err. No register change.
  - Then return to IDLE.
- Write latency: regs_out and wr_strobe change exactly 4 clk rising edges after the cs_n pin rise (2 synchroniser + 1 edge detect + 1 commit).

Boundary cases:
- cs_n rise and a sclk edge detected in the same clk: the cs_n rise takes priority, and that sclk edge is not counted.
- err_clr in the same cycle as a new error: the error wins, so frame_err stays 1.
- sclk edges while cs_n is high: ignored.
- rst mid-frame: everything returns to reset values, and the partial frame is lost.

Decomposition:
- Shared package spi_reg_pkg holds: FRAME_BITS = 16, CMD_BITS = 8, ADDR_W = 7, DATA_W = 8, the state encoding (IDLE, CMD, DATA), and the WR/RD opcode constants.
- One sub-module, sync_edge: 2-FF synchroniser plus rise/fall pulse outputs. Instantiate it 3 times (sclk, cs_n, mosi; mosi uses the level output only).

Test Plan:
- Write 0x8 1A5 (cmd 0x81 = write addr 1, data 0xA5), NREGS = 4 → regs_out[15:8] = 0xA5 exactly 4 clk after cs_n rises; wr_strobe is high for 1 clk; wr_addr = 1; other regs stay 0x00.
- After that write, read frame 0x0100 → miso shifts out 1010_0101 during bits 8..15; regs_out unchanged; no strobe.
- 15-bit frame 0x82 then 7 data bits; also a 17-bit frame → no register change; frame_err = 1 and stays 1 after a valid frame; pulse err_clr → frame_err = 0.
- Write addr 0x10 (≥ NREGS) with data 0xFF → no change, no strobe, frame_err = 0. A read of addr 0x10 returns 0x00.
- Assert rst after 9 bits of a write to addr 2 → regs = RESET_VAL, miso = 0; cs_n rise after rst release sets no error and commits nothing. A following good write to addr 2 with 0x3C succeeds.
- cs_n rise coincident with a 16th sclk rising edge (same clk after sync) → count = 15, frame rejected, frame_err = 1.
